divu_hilo_unit: RTL and testbench

- Sequential unsigned restoring divider plus HI/LO register pair.
- Sits directly downstream of the ALU control stage and consumes its 6-bit SignaltoDIV code.
- Control holds DIVU (6'b011011) while dividing, then emits HILO_WR (6'b111111) to commit; this block executes the iterations and commits remainder to HI and quotient to LO.
- Drives MFHI/MFLO read data toward the result mux.

---
 rtl/divu_hilo_if.sv | 35 +++
 rtl/divu_hilo_unit.sv | 152 +++++++++++++++
 tb/tb_divu_hilo_unit.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/divu_hilo_if.sv
// Handshake bundle between the ALU control stage, the HI/LO divider and the result mux.
// Carries div_zero only when DIVU_ZERO_FAST_EN is defined.
interface divu_hilo_if #(
    parameter int WIDTH = 32
);
    logic [5:0]       ctrl;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] rd_data;
    logic             busy;
    logic             done;
`ifdef DIVU_ZERO_FAST_EN
    logic             div_zero;

    modport master (
        output ctrl, dividend, divisor,
        input  hi, lo, rd_data, busy, done, div_zero
    );
    modport slave (
        input  ctrl, dividend, divisor,
        output hi, lo, rd_data, busy, done, div_zero
    );
`else
    modport master (
        output ctrl, dividend, divisor,
        input  hi, lo, rd_data, busy, done
    );
    modport slave (
        input  ctrl, dividend, divisor,
        output hi, lo, rd_data, busy, done
    );
`endif
endinterface

// File: rtl/divu_hilo_unit.sv
// Sequential unsigned restoring divider with HI/LO commit and MFHI/MFLO read mux.
// Optional DIVU_ZERO_FAST_EN: zero divisor skips iteration and flags div_zero.
module divu_hilo_unit #(
    parameter int          WIDTH        = 32,
    parameter logic [5:0]  DIVU_CODE    = 6'b011011,
    parameter logic [5:0]  HILO_WR_CODE = 6'b111111,
    parameter logic [5:0]  MFHI_CODE    = 6'b010000,
    parameter logic [5:0]  MFLO_CODE    = 6'b010010
) (
    input logic        clk,
    input logic        rst_n,
    divu_hilo_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_nstate;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [CW-1:0]    r_cnt;
    logic             r_pend;
    logic             r_done;

    logic             w_load;
    logic             w_step;
    logic             w_commit;
    logic             w_last;
    logic             w_wr;
    logic             w_ge;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH-1:0] w_diff;

    assign w_wr     = (bus.ctrl == HILO_WR_CODE);
    assign w_last   = (r_cnt == CW'(WIDTH - 1));
    // Shifted remainder keeps the carry-out bit so the compare is exact.
    assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};
    assign w_ge     = (w_rem_sh >= {1'b0, r_div});
    assign w_diff   = w_rem_sh[WIDTH-1:0] - r_div;

    always_comb begin
        w_nstate = r_state;
        w_load   = 1'b0;
        w_step   = 1'b0;
        w_commit = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.ctrl == DIVU_CODE) begin
                    w_load   = 1'b1;
                    w_nstate = S_RUN;
`ifdef DIVU_ZERO_FAST_EN
                    if (bus.divisor == '0)
                        w_nstate = S_DONE;
`endif
                end
            end
            S_RUN: begin
                w_step = 1'b1;
                if (w_last)
                    w_nstate = S_DONE;
            end
            S_DONE: begin
                if (r_pend || w_wr) begin
                    w_commit = 1'b1;
                    w_nstate = S_IDLE;
                end
            end
            default: w_nstate = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_nstate;
    end

`ifdef DIVU_ZERO_FAST_EN
    logic r_dz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_dz <= 1'b0;
        else if (w_load)
            r_dz <= (bus.divisor == '0);
    end

    assign bus.div_zero = r_dz;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_quo  <= '0;
            r_rem  <= '0;
            r_div  <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_cnt  <= '0;
            r_pend <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_commit;
            if (w_load) begin
                r_quo  <= bus.dividend;
                r_div  <= bus.divisor;
                r_rem  <= '0;
                r_cnt  <= '0;
                r_pend <= 1'b0;
`ifdef DIVU_ZERO_FAST_EN
                if (bus.divisor == '0) begin
                    r_quo <= '1;
                    r_rem <= bus.dividend;
                end
`endif
            end
            if (w_step) begin
                r_quo <= {r_quo[WIDTH-2:0], w_ge};
                r_rem <= w_ge ? w_diff : w_rem_sh[WIDTH-1:0];
                r_cnt <= r_cnt + 1'b1;
                if (w_wr)
                    r_pend <= 1'b1;
            end
            if (w_commit) begin
                r_hi   <= r_rem;
                r_lo   <= r_quo;
                r_pend <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.rd_data = '0;
        if (bus.ctrl == MFHI_CODE)
            bus.rd_data = r_hi;
        else if (bus.ctrl == MFLO_CODE)
            bus.rd_data = r_lo;
    end

    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
    assign bus.busy = (r_state != S_IDLE);
    assign bus.done = r_done;
endmodule

// File: tb/tb_divu_hilo_unit.sv
// Directed bench for divu_hilo_unit: vector table plus reset, early-commit
// and wait-in-DONE sequences.
module tb_divu_hilo_unit;
    localparam int         W      = 32;
    localparam logic [5:0] C_DIVU = 6'b011011;
    localparam logic [5:0] C_WR   = 6'b111111;
    localparam logic [5:0] C_MFHI = 6'b010000;
    localparam logic [5:0] C_MFLO = 6'b010010;
    localparam logic [5:0] C_ADD  = 6'b100000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    divu_hilo_if #(.WIDTH(W)) bus ();

    divu_hilo_unit #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
    } vec_t;

    vec_t v[5];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_steps(input int n, input logic [5:0] c);
        bus.ctrl = c;
        for (int i = 0; i < n; i++)
            tick();
    endtask

    initial begin
        int steps;

        v[0] = '{a: 32'd100,        b: 32'd7, q: 32'd14,        r: 32'd2};
        v[1] = '{a: 32'hFFFF_FFFF,  b: 32'd1, q: 32'hFFFF_FFFF, r: 32'd0};
        v[2] = '{a: 32'd5,          b: 32'd9, q: 32'd0,         r: 32'd5};
        v[3] = '{a: 32'h1234,       b: 32'd0, q: 32'hFFFF_FFFF, r: 32'h1234};
        v[4] = '{a: 32'd81,         b: 32'd9, q: 32'd9,         r: 32'd0};

        rst_n        = 1'b0;
        bus.ctrl     = C_ADD;
        bus.dividend = '0;
        bus.divisor  = '0;
        run_steps(3, C_ADD);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_hi", bus.hi, 32'd0);
        chk("rst_lo", bus.lo, 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);

        // Reset in the middle of a division
        rst_n        = 1'b1;
        bus.dividend = 32'd100;
        bus.divisor  = 32'd7;
        run_steps(6, C_DIVU);
        chk("mid_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(bus.busy), 32'd0);
        tick();
        rst_n = 1'b1;
        run_steps(2, C_WR);
        chk("idle_wr_hi", bus.hi, 32'd0);
        chk("idle_wr_lo", bus.lo, 32'd0);
        chk("idle_wr_done", 32'(bus.done), 32'd0);
        chk("idle_wr_busy", 32'(bus.busy), 32'd0);

        foreach (v[k]) begin
            bus.dividend = v[k].a;
            bus.divisor  = v[k].b;
            run_steps(1, C_DIVU);
            bus.dividend = 32'hDEAD_BEEF;
            bus.divisor  = 32'd3;
`ifdef DIVU_ZERO_FAST_EN
            chk($sformatf("v%0d_dz", k), 32'(bus.div_zero),
                32'(v[k].b == '0));
            steps = (v[k].b == '0) ? 0 : W;
`else
            steps = W;
`endif
            run_steps(steps, C_DIVU);
            chk($sformatf("v%0d_busy", k), 32'(bus.busy), 32'd1);
            chk($sformatf("v%0d_pre", k), 32'(bus.done), 32'd0);
            run_steps(1, C_WR);
            chk($sformatf("v%0d_done", k), 32'(bus.done), 32'd1);
            chk($sformatf("v%0d_lo", k), bus.lo, v[k].q);
            chk($sformatf("v%0d_hi", k), bus.hi, v[k].r);
            chk($sformatf("v%0d_idle", k), 32'(bus.busy), 32'd0);
            bus.ctrl = C_MFHI;
            #1;
            chk($sformatf("v%0d_mfhi", k), bus.rd_data, v[k].r);
            bus.ctrl = C_MFLO;
            #1;
            chk($sformatf("v%0d_mflo", k), bus.rd_data, v[k].q);
            bus.ctrl = C_ADD;
            #1;
            chk($sformatf("v%0d_add", k), bus.rd_data, 32'd0);
            run_steps(1, C_ADD);
            chk($sformatf("v%0d_pulse", k), 32'(bus.done), 32'd0);
        end

        // HILO_WR on the 10th RUN edge commits on the edge after DONE entry
        bus.dividend = 32'd1000;
        bus.divisor  = 32'd3;
        run_steps(1, C_DIVU);
        run_steps(9, C_ADD);
        run_steps(1, C_WR);
        run_steps(W - 10, C_ADD);
        chk("early_nodone", 32'(bus.done), 32'd0);
        chk("early_busy", 32'(bus.busy), 32'd1);
        chk("early_hi_old", bus.hi, 32'd0);
        chk("early_lo_old", bus.lo, 32'd9);
        run_steps(1, C_ADD);
        chk("early_done", 32'(bus.done), 32'd1);
        chk("early_lo", bus.lo, 32'd333);
        chk("early_hi", bus.hi, 32'd1);
        run_steps(1, C_ADD);
        chk("early_pulse", 32'(bus.done), 32'd0);

        // Result waits in DONE until HILO_WR arrives
        bus.dividend = 32'd7;
        bus.divisor  = 32'd2;
        run_steps(1, C_DIVU);
        run_steps(W + 5, C_ADD);
        chk("wait_busy", 32'(bus.busy), 32'd1);
        chk("wait_lo", bus.lo, 32'd333);
        chk("wait_done", 32'(bus.done), 32'd0);
        run_steps(1, C_WR);
        chk("wait_cdone", 32'(bus.done), 32'd1);
        chk("wait_clo", bus.lo, 32'd3);
        chk("wait_chi", bus.hi, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
